// File: rtl/spi_loopback_bist.sv
// SPI loopback built-in self-test: drives an internal SPI master with generated
// patterns, compares each received word against the transmitted one and counts errors.
module spi_loopback_bist #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       NUM_PATTERNS = 16,
  parameter int unsigned       CLK_DIV      = 2,
  parameter bit                CPOL         = 1'b0,
  parameter bit                CPHA         = 1'b0,
  parameter logic [DATA_W-1:0] LFSR_POLY    = 8'hB8,
  parameter int unsigned       ERR_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pat_mode,
  input  logic [DATA_W-1:0] seed,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [15:0]       pat_idx,
  output logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic [2:0]        code
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CS_SETUP = 3'd2,
    S_SHIFT    = 3'd3,
    S_CS_HOLD  = 3'd4,
    S_CHECK    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  function automatic logic [DATA_W-1:0] checker_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < DATA_W; i += 2) w[i] = 1'b1;
    return w;
  endfunction

  localparam logic [DATA_W-1:0] CHECKER_EVEN = checker_word();
  localparam logic [15:0]       DIV_LAST     = 16'(CLK_DIV - 1);
  localparam logic [6:0]        EDGE_LAST    = 7'(2 * DATA_W - 1);
  localparam logic [15:0]       IDX_LAST     = 16'(NUM_PATTERNS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX      = '1;

  // Patterns are produced incrementally: gen holds pattern(pat_idx) and is
  // advanced once per CHECK, so no per-frame modulo or multiply is needed.
  function automatic logic [DATA_W-1:0] pat_first(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] s);
    case (mode)
      2'd0:    return s;
      2'd1:    return (s == '0) ? '1 : s;
      2'd2:    return {{(DATA_W-1){1'b0}}, 1'b1};
      default: return CHECKER_EVEN;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] mode,
                                                 input logic [DATA_W-1:0] x);
    case (mode)
      2'd0:    return x + {{(DATA_W-1){1'b0}}, 1'b1};
      2'd1:    return (x >> 1) ^ (x[0] ? LFSR_POLY : '0);
      2'd2:    return {x[DATA_W-2:0], x[DATA_W-1]};
      default: return ~x;
    endcase
  endfunction

  state_t            state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] gen;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [15:0]       div_cnt;
  logic [6:0]        edge_cnt;
  logic [ERR_W-1:0]  err_next;

  assign code = state;

  always_comb begin
    err_next = err_count;
    if (rx_data != tx_data && err_count != ERR_MAX)
      err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      gen       <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= CPOL;
      spi_mosi  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      pat_idx   <= '0;
      tx_data   <= '0;
      rx_data   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q    <= pat_mode;
            gen       <= pat_first(pat_mode, seed);
            err_count <= '0;
            pat_idx   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_data  <= gen;
          tx_sh    <= gen;
          rx_sh    <= '0;
          spi_cs_n <= 1'b0;
          spi_mosi <= CPHA ? 1'b0 : gen[DATA_W-1];
          div_cnt  <= '0;
          state    <= S_CS_SETUP;
        end
        S_CS_SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_cnt + 7'd1;
            // Even edges are leading; the sampling edge is the leading one only when CPHA=0.
            if (~edge_cnt[0] ^ CPHA) begin
              rx_sh <= {rx_sh[DATA_W-2:0], spi_miso};
            end else begin
              spi_mosi <= CPHA ? tx_sh[DATA_W-1] : tx_sh[DATA_W-2];
              tx_sh    <= tx_sh << 1;
            end
            if (edge_cnt == EDGE_LAST) begin
              spi_cs_n <= 1'b1;
              state    <= S_CS_HOLD;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        S_CS_HOLD: begin
          rx_data  <= rx_sh;
          spi_mosi <= 1'b0;
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= S_CHECK;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        S_CHECK: begin
          err_count <= err_next;
          if (pat_idx == IDX_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            pat_idx <= pat_idx + 16'd1;
            gen     <= pat_next(mode_q, gen);
            state   <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_loopback_bist.sv
// Scoreboard bench for spi_loopback_bist: default, saturating (ERR_W=3) and
// 16-bit CPOL=1/CPHA=1 instances, checked frame by frame at each CHECK state.
module tb_spi_loopback_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b, start_c;
  logic [1:0]  mode_a, mode_b, mode_c;
  logic [7:0]  seed_a, seed_b;
  logic [15:0] seed_c;
  logic        tie0_a;

  logic        cs_n_a, sclk_a, mosi_a, miso_a, busy_a, done_a, pass_a;
  logic [7:0]  err_a;
  logic [15:0] idx_a;
  logic [7:0]  tx_a, rx_a;
  logic [2:0]  code_a;

  logic        cs_n_b, sclk_b, mosi_b, busy_b, done_b, pass_b;
  logic [2:0]  err_b;
  logic [15:0] idx_b;
  logic [7:0]  tx_b, rx_b;
  logic [2:0]  code_b;

  logic        cs_n_c, sclk_c, mosi_c, busy_c, done_c, pass_c;
  logic [7:0]  err_c;
  logic [15:0] idx_c;
  logic [15:0] tx_c, rx_c;
  logic [2:0]  code_c;

  assign miso_a = tie0_a ? 1'b0 : mosi_a;

  spi_loopback_bist u_a (
    .clk(clk), .reset(rst), .start(start_a), .pat_mode(mode_a), .seed(seed_a),
    .spi_cs_n(cs_n_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .pat_idx(idx_a), .tx_data(tx_a), .rx_data(rx_a), .code(code_a)
  );

  spi_loopback_bist #(.ERR_W(3)) u_b (
    .clk(clk), .reset(rst), .start(start_b), .pat_mode(mode_b), .seed(seed_b),
    .spi_cs_n(cs_n_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(1'b0),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .pat_idx(idx_b), .tx_data(tx_b), .rx_data(rx_b), .code(code_b)
  );

  spi_loopback_bist #(.DATA_W(16), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1),
                      .LFSR_POLY(16'hB400)) u_c (
    .clk(clk), .reset(rst), .start(start_c), .pat_mode(mode_c), .seed(seed_c),
    .spi_cs_n(cs_n_c), .spi_sclk(sclk_c), .spi_mosi(mosi_c), .spi_miso(mosi_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .pat_idx(idx_c), .tx_data(tx_c), .rx_data(rx_c), .code(code_c)
  );

  typedef struct {
    logic [31:0] tx;
    logic [31:0] rx;
    logic [31:0] idx;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_c[$];
  exp_t        e_a, e_c;
  logic [31:0] log_a[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_pat(input int w, input int mode, input logic [31:0] s,
                                            input int idx, input logic [31:0] poly);
    logic [31:0] mask, x;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    x = 32'h0;
    case (mode)
      0: x = (s + 32'(idx)) & mask;
      1: begin
        x = s & mask;
        if (x == 32'h0) x = mask;
        for (int k = 0; k < idx; k++) x = (x >> 1) ^ (x[0] ? poly : 32'h0);
      end
      2: x = 32'h1 << (idx % w);
      default: for (int b = 0; b < w; b++) x[b] = ((b % 2) == (idx % 2));
    endcase
    return x;
  endfunction

  always @(negedge clk) begin
    if (!rst && code_a == 3'd5) begin
      if (q_a.size() == 0) begin
        check("a_queue_underflow", 32'(q_a.size()), 32'd1);
      end else begin
        e_a = q_a.pop_front();
        log_a.push_back(32'(tx_a));
        check("a_tx", 32'(tx_a), e_a.tx);
        check("a_rx", 32'(rx_a), e_a.rx);
        check("a_idx", 32'(idx_a), e_a.idx);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && code_c == 3'd5) begin
      if (q_c.size() == 0) begin
        check("c_queue_underflow", 32'(q_c.size()), 32'd1);
      end else begin
        e_c = q_c.pop_front();
        check("c_tx", 32'(tx_c), e_c.tx);
        check("c_rx", 32'(rx_c), e_c.rx);
        check("c_idx", 32'(idx_c), e_c.idx);
      end
    end
  end

  task automatic push_a(input int mode, input logic [7:0] s, input bit tied);
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      t = model_pat(8, mode, 32'(s), i, 32'hB8);
      q_a.push_back('{tx: t, rx: (tied ? 32'h0 : t), idx: 32'(i)});
    end
  endtask

  task automatic start_run_a(input logic [1:0] mode, input logic [7:0] s);
    @(negedge clk);
    mode_a  = mode;
    seed_a  = s;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_load_entry", 32'(code_a), 32'd1);
  endtask

  // Counts cycles from LOAD entry to done; optionally pulses start at cycle poke_at.
  task automatic wait_done_a(input int budget, input int poke_at, output int cyc);
    cyc = 0;
    while (!done_a && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke_at) begin
        check("a_poke_in_shift", 32'(code_a), 32'd3);
        start_a = 1'b1;
      end else begin
        start_a = 1'b0;
      end
    end
    if (!done_a) check("a_done_timeout", 32'(done_a), 32'd1);
  endtask

  int cyc;
  int lim;
  logic [31:0] lfsr_ref [6];

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
    seed_a = 8'h00; seed_b = 8'h00; seed_c = 16'h0000;
    tie0_a = 1'b0;
    lfsr_ref = '{32'h01, 32'hB8, 32'h5C, 32'h2E, 32'h17, 32'hB3};
    repeat (3) @(negedge clk);

    check("rst_cs_n", 32'(cs_n_a), 32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd0);
    check("rst_mosi", 32'(mosi_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_idx", 32'(idx_a), 32'd0);
    check("rst_tx", 32'(tx_a), 32'd0);
    check("rst_rx", 32'(rx_a), 32'd0);
    check("rst_code", 32'(code_a), 32'd0);
    check("rst_sclk_c", 32'(sclk_c), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // increment, seed 0, loopback
    push_a(0, 8'h00, 1'b0);
    start_run_a(2'd0, 8'h00);
    wait_done_a(700, -1, cyc);
    check("inc_cycles", 32'(cyc), 32'd608);
    check("inc_err", 32'(err_a), 32'd0);
    check("inc_pass", 32'(pass_a), 32'd1);
    check("inc_idx", 32'(idx_a), 32'd15);
    check("inc_busy", 32'(busy_a), 32'd0);
    check("inc_tx_last", 32'(tx_a), 32'h0F);

    // LFSR seed 1, restarted straight from DONE
    log_a.delete();
    push_a(1, 8'h01, 1'b0);
    start_run_a(2'd1, 8'h01);
    check("restart_done_clr", 32'(done_a), 32'd0);
    check("restart_pass_clr", 32'(pass_a), 32'd0);
    check("restart_busy", 32'(busy_a), 32'd1);
    wait_done_a(700, -1, cyc);
    check("lfsr_pass", 32'(pass_a), 32'd1);
    lim = (log_a.size() < 6) ? log_a.size() : 6;
    check("lfsr_log_len", 32'(lim), 32'd6);
    for (int i = 0; i < lim; i++) check("lfsr_seq", log_a[i], lfsr_ref[i]);

    // LFSR seed 0 substitutes all-ones
    log_a.delete();
    push_a(1, 8'h00, 1'b0);
    start_run_a(2'd1, 8'h00);
    wait_done_a(700, -1, cyc);
    check("lfsr0_first", (log_a.size() > 0) ? log_a[0] : 32'hDEAD, 32'hFF);
    check("lfsr0_pass", 32'(pass_a), 32'd1);

    // checkerboard with miso tied low on both 8-bit instances
    tie0_a = 1'b1;
    push_a(3, 8'h5A, 1'b1);
    @(negedge clk);
    mode_a = 2'd3; seed_a = 8'h5A; mode_b = 2'd3; seed_b = 8'h5A;
    start_a = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    wait_done_a(700, -1, cyc);
    check("chk_err", 32'(err_a), 32'd16);
    check("chk_pass", 32'(pass_a), 32'd0);
    check("sat_done", 32'(done_b), 32'd1);
    check("sat_err", 32'(err_b), 32'd7);
    check("sat_pass", 32'(pass_b), 32'd0);
    tie0_a = 1'b0;

    // 16-bit, CPOL=1, CPHA=1, CLK_DIV=1, walking one
    check("c_idle_sclk", 32'(sclk_c), 32'd1);
    for (int i = 0; i < 16; i++)
      q_c.push_back('{tx: model_pat(16, 2, 32'h0, i, 32'hB400),
                      rx: model_pat(16, 2, 32'h0, i, 32'hB400), idx: 32'(i)});
    @(negedge clk);
    mode_c = 2'd2; seed_c = 16'h1234; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    cyc = 0;
    while (!done_c && cyc < 700) begin
      @(negedge clk);
      cyc++;
      if (code_c == 3'd2 && sclk_c !== 1'b1) check("c_setup_sclk", 32'(sclk_c), 32'd1);
    end
    check("c_cycles", 32'(cyc), 32'd576);
    check("c_pass", 32'(pass_c), 32'd1);
    check("c_tx_last", 32'(tx_c), 32'h8000);
    check("c_end_sclk", 32'(sclk_c), 32'd1);

    // start pulsed during SHIFT is ignored
    push_a(0, 8'h30, 1'b0);
    start_run_a(2'd0, 8'h30);
    wait_done_a(700, 20, cyc);
    check("poke_cycles", 32'(cyc), 32'd608);
    check("poke_pass", 32'(pass_a), 32'd1);
    check("poke_idx", 32'(idx_a), 32'd15);

    // asynchronous reset mid-SHIFT on frame 3, then a clean run
    push_a(0, 8'h00, 1'b0);
    start_run_a(2'd0, 8'h00);
    cyc = 0;
    while (!(idx_a == 16'd3 && code_a == 3'd3) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_shift_reached", 32'(code_a), 32'd3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_cs_n", 32'(cs_n_a), 32'd1);
    check("arst_sclk", 32'(sclk_a), 32'd0);
    check("arst_code", 32'(code_a), 32'd0);
    check("arst_err", 32'(err_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q_a.delete();
    push_a(0, 8'h80, 1'b0);
    start_run_a(2'd0, 8'h80);
    check("rerun_idx0", 32'(idx_a), 32'd0);
    wait_done_a(700, -1, cyc);
    check("rerun_cycles", 32'(cyc), 32'd608);
    check("rerun_pass", 32'(pass_a), 32'd1);
    check("rerun_tx_last", 32'(tx_a), 32'h8F);
    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_c_drained", 32'(q_c.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
